// File: rtl/zeroriscy_multdiv_seq_if.sv
// rtl/zeroriscy_multdiv_seq_if.sv - ID/EX request and borrowed ALU adder signals of the sequential mult/div unit
interface zeroriscy_multdiv_seq_if;
  logic        multdiv_en_i;
  logic [1:0]  operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [33:0] alu_adder_ext_i;
  logic [32:0] alu_operand_a_o;
  logic [32:0] alu_operand_b_o;
  logic        alu_en_o;
  logic        ready_o;
  logic [31:0] result_o;

  modport slave (
    input  multdiv_en_i, operator_i, signed_mode_i, op_a_i, op_b_i, alu_adder_ext_i,
    output alu_operand_a_o, alu_operand_b_o, alu_en_o, ready_o, result_o
  );

  modport master (
    output multdiv_en_i, operator_i, signed_mode_i, op_a_i, op_b_i, alu_adder_ext_i,
    input  alu_operand_a_o, alu_operand_b_o, alu_en_o, ready_o, result_o
  );
endinterface

// File: rtl/zeroriscy_multdiv_seq.sv
// rtl/zeroriscy_multdiv_seq.sv - radix-2 RV32M mult/div using the ALU adder; optional MULTDIV_DIVZERO_FASTPATH_EN
module zeroriscy_multdiv_seq (
  input  logic                   clk,
  input  logic                   rst,
  zeroriscy_multdiv_seq_if.slave md
);
  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, COMP, LAST, CHANGE_SIGN, FINISH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  operator_q, operator_d;
  logic [1:0]  sign_q, sign_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic        b_zero_q, b_zero_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] result_q, result_d;
  logic [32:0] alu_a, alu_b;

  logic [31:0] sum;
  logic        carry;
  logic        is_div;
  logic [32:0] pp;
  logic        mul_c32, mul_s32, mul_s33;
  logic [32:0] rem_sh;
  logic        ge;
  logic        neg_res;
  logic [31:0] sign_val;
  logic        unused_ext_lsb;

  assign sum            = md.alu_adder_ext_i[32:1];
  assign carry          = md.alu_adder_ext_i[33];
  assign unused_ext_lsb = md.alu_adder_ext_i[0];
  assign is_div         = operator_q[1];

  // Multiply: 33-bit accumulator; bits 32/33 of the exact sum are rebuilt from the adder carry-out.
  assign pp      = quo_q[0] ? {a_neg_q, op_a_q} : 33'd0;
  assign mul_s32 = acc_q[32] ^ pp[32] ^ carry;
  assign mul_c32 = (acc_q[32] & pp[32]) | (carry & (acc_q[32] ^ pp[32]));
  assign mul_s33 = acc_q[32] ^ pp[32] ^ mul_c32;

  // Divide: the 32-bit difference MSB is a borrow flag only when both MSBs agree.
  assign rem_sh = {acc_q[31:0], quo_q[31]};
  assign ge     = rem_sh[32] |
                  ((rem_sh[31] == op_b_q[31]) ? ~md.alu_adder_ext_i[32] : rem_sh[31]);

  assign neg_res  = (operator_q == MD_OP_DIV) ? ((&sign_q) & (a_neg_q ^ b_neg_q) & ~b_zero_q)
                                               : a_neg_q;
  assign sign_val = (operator_q == MD_OP_REM) ? acc_q[31:0] : quo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      operator_q <= 2'b00;
      sign_q     <= 2'b00;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      acc_q      <= 33'd0;
      quo_q      <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      operator_q <= operator_d;
      sign_q     <= sign_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      b_zero_q   <= b_zero_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    operator_d = operator_q;
    sign_d     = sign_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    b_zero_d   = b_zero_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    result_d   = result_q;
    alu_a      = 33'd0;
    alu_b      = 33'd0;

    if (state_q != IDLE && state_q != FINISH && !md.multdiv_en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md.multdiv_en_i) begin
            operator_d = md.operator_i;
            sign_d     = md.signed_mode_i;
            a_neg_d    = md.signed_mode_i[0] & md.op_a_i[31];
            b_neg_d    = md.signed_mode_i[1] & md.op_b_i[31];
            b_zero_d   = (md.op_b_i == 32'd0);
            op_a_d     = md.op_a_i;
            op_b_d     = md.op_b_i;
            acc_d      = 33'd0;
            quo_d      = md.op_b_i;
            cnt_d      = 5'd31;
            state_d    = (md.operator_i == MD_OP_MULL || md.operator_i == MD_OP_MULH) ? COMP : ABS_A;
`ifdef MULTDIV_DIVZERO_FASTPATH_EN
            if (md.operator_i[1] && (md.op_b_i == 32'd0)) begin
              state_d  = FINISH;
              result_d = (md.operator_i == MD_OP_DIV) ? 32'hFFFF_FFFF : md.op_a_i;
            end
`endif
          end
        end
        ABS_A: begin
          alu_a   = {32'd0, 1'b1};
          alu_b   = {~op_a_q, 1'b1};
          quo_d   = a_neg_q ? sum : op_a_q;
          state_d = ABS_B;
        end
        ABS_B: begin
          alu_a   = {32'd0, 1'b1};
          alu_b   = {~op_b_q, 1'b1};
          op_b_d  = b_neg_q ? sum : op_b_q;
          state_d = COMP;
        end
        COMP: begin
          cnt_d = (cnt_q != 5'd0) ? cnt_q - 5'd1 : cnt_q;
          if (is_div) begin
            alu_a = {rem_sh[31:0], 1'b1};
            alu_b = {~op_b_q, 1'b1};
            acc_d = {1'b0, ge ? sum : rem_sh[31:0]};
            quo_d = {quo_q[30:0], ge};
            if (cnt_q == 5'd0) state_d = CHANGE_SIGN;
          end else begin
            alu_a = {acc_q[31:0], 1'b0};
            alu_b = {pp[31:0], 1'b0};
            acc_d = {mul_s33, mul_s32, sum[31:1]};
            quo_d = {sum[0], quo_q[31:1]};
            if (cnt_q == 5'd0) begin
              if (operator_q == MD_OP_MULH) begin
                state_d = LAST;
              end else begin
                state_d  = FINISH;
                result_d = {sum[0], quo_q[31:1]};
              end
            end
          end
        end
        LAST: begin
          // Multiplier bits were weighted unsigned; a negative signed B owes one A * 2^32.
          if (b_neg_q) begin
            alu_a = {acc_q[31:0], 1'b1};
            alu_b = {~op_a_q, 1'b1};
          end else begin
            alu_a = {acc_q[31:0], 1'b0};
          end
          result_d = sum;
          state_d  = FINISH;
        end
        CHANGE_SIGN: begin
          if (neg_res) begin
            alu_a = {32'd0, 1'b1};
            alu_b = {~sign_val, 1'b1};
          end else begin
            alu_a = {sign_val, 1'b0};
          end
          result_d = sum;
          state_d  = FINISH;
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign md.alu_operand_a_o = alu_a;
  assign md.alu_operand_b_o = alu_b;
  assign md.alu_en_o        = (state_q == ABS_A) || (state_q == ABS_B) || (state_q == COMP) ||
                              (state_q == LAST) || (state_q == CHANGE_SIGN);
  assign md.ready_o         = (state_q == FINISH);
  assign md.result_o        = result_q;
endmodule

// File: tb/tb_zeroriscy_multdiv_seq.sv
// tb/tb_zeroriscy_multdiv_seq.sv - randomized self-checking bench for zeroriscy_multdiv_seq
module tb_zeroriscy_multdiv_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  zeroriscy_multdiv_seq_if bus();

  zeroriscy_multdiv_seq dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  // ALU stand-in: plain 34-bit sum of the two 33-bit multdiv operands.
  assign bus.alu_adder_ext_i = {1'b0, bus.alu_operand_a_o} + {1'b0, bus.alu_operand_b_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [31:0] r;
    sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    case (op)
      2'b00: begin p = sa * sb; r = p[31:0];  end
      2'b01: begin p = sa * sb; r = p[63:32]; end
      2'b10: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit fast_divzero(input logic [1:0] op, input logic [31:0] b);
`ifdef MULTDIV_DIVZERO_FASTPATH_EN
    return op[1] && (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    if (fast_divzero(op, b)) return 1;
    if (op == 2'b00) return 33;
    if (op == 2'b01) return 34;
    return 36;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b);
    bus.multdiv_en_i  = 1'b1;
    bus.operator_i    = op;
    bus.signed_mode_i = sm;
    bus.op_a_i        = a;
    bus.op_b_i        = b;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b);
    int   lat;
    logic seen_ready, saw_alu;
    logic [31:0] exp_res;
    exp_res = ref_result(op, sm, a, b);
    @(negedge clk);
    drive(op, sm, a, b);
    lat = 0; seen_ready = 1'b0; saw_alu = 1'b0;
    while (!seen_ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready_o) seen_ready = 1'b1;
      else saw_alu = saw_alu | bus.alu_en_o;
    end
    bus.multdiv_en_i = 1'b0;
    check({tag, " ready"},   64'(seen_ready), 64'(1));
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(op, b)));
    check({tag, " result"},  64'(bus.result_o), 64'(exp_res));
    check({tag, " alu_en_finish"}, 64'(bus.alu_en_o), 64'(0));
    check({tag, " alu_used"}, 64'(saw_alu), 64'(!fast_divzero(op, b)));
    @(posedge clk); #1;
    check({tag, " ready_pulse"}, 64'(bus.ready_o), 64'(0));
    check({tag, " result_hold"}, 64'(bus.result_o), 64'(exp_res));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  op, sm;
    logic [31:0] a, b, held;
    logic        any_ready;

    rst = 1'b1;
    bus.multdiv_en_i  = 1'b0;
    bus.operator_i    = 2'b00;
    bus.signed_mode_i = 2'b00;
    bus.op_a_i        = 32'd0;
    bus.op_b_i        = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready",  64'(bus.ready_o), 64'(0));
    check("reset result", 64'(bus.result_o), 64'(0));
    check("reset alu_en", 64'(bus.alu_en_o), 64'(0));
    check("reset alu_a",  64'(bus.alu_operand_a_o), 64'(0));
    check("reset alu_b",  64'(bus.alu_operand_b_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("mull_7_m3",      2'b00, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD);
    run_op("mulh_min_min",   2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_ones",     2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2",       2'b10, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("rem_m7_2",       2'b11, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("div_by_zero",    2'b10, 2'b00, 32'h0000_1234, 32'h0000_0000);
    run_op("rem_by_zero",    2'b11, 2'b00, 32'h0000_1234, 32'h0000_0000);
    run_op("div_sdivzero",   2'b10, 2'b11, 32'hFFFF_FFF9, 32'h0000_0000);
    run_op("div_overflow",   2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_overflow",   2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 50; i++) begin
      op = 2'($urandom_range(0, 3));
      sm = op[1] ? ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      run_op($sformatf("rnd%0d_op%0d_sm%0d", i, op, sm), op, sm, a, b);
    end

    // Abort a MULL after ten COMP iterations.
    held = bus.result_o;
    @(negedge clk);
    drive(2'b00, 2'b00, $urandom, $urandom);
    repeat (11) @(posedge clk);
    #1;
    bus.multdiv_en_i = 1'b0;
    @(posedge clk); #1;
    check("abort ready",  64'(bus.ready_o), 64'(0));
    check("abort alu_en", 64'(bus.alu_en_o), 64'(0));
    check("abort alu_a",  64'(bus.alu_operand_a_o), 64'(0));
    any_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      any_ready = any_ready | bus.ready_o;
    end
    check("abort no_ready",    64'(any_ready), 64'(0));
    check("abort result_hold", 64'(bus.result_o), 64'(held));

    run_op("after_abort_mulh", 2'b01, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset in the middle of a signed divide.
    @(negedge clk);
    drive(2'b10, 2'b11, 32'hDEAD_BEEF, 32'h0000_0013);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.multdiv_en_i = 1'b0;
    @(posedge clk); #1;
    check("midrst ready",  64'(bus.ready_o), 64'(0));
    check("midrst result", 64'(bus.result_o), 64'(0));
    check("midrst alu_en", 64'(bus.alu_en_o), 64'(0));
    check("midrst alu_a",  64'(bus.alu_operand_a_o), 64'(0));
    check("midrst alu_b",  64'(bus.alu_operand_b_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("mull_3x5", 2'b00, 2'b00, 32'd3, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zeroriscy_multdiv_seq.md
# zeroriscy_multdiv_seq

Sequential RV32M multiply/divide unit for the zero-riscy EX stage. It does not contain its own adder. Instead it borrows the ALU's 33-bit adder through the ALU's multdiv operand/enable inputs and reads back the 34-bit extended sum. Operands are accepted from the ID/EX pipeline, the unit iterates radix-2, and it returns a 32-bit result with a single-cycle ready pulse.

## Interface
Parameters:
- none; opcodes are fixed: MD_OP_MULL=2'b00, MD_OP_MULH=2'b01, MD_OP_DIV=2'b10, MD_OP_REM=2'b11.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- multdiv_en_i  in  1  request; held high until ready_o
- operator_i  in  2  MD_OP_* code
- signed_mode_i  in  2  bit0 = operand A signed, bit1 = operand B signed
- op_a_i  in  32  rs1
- op_b_i  in  32  rs2
- alu_adder_ext_i  in  34  extended adder sum from the ALU
- alu_operand_a_o  out  33  to the ALU multdiv operand A
- alu_operand_b_o  out  33  to the ALU multdiv operand B
- alu_en_o  out  1  to the ALU multdiv enable; selects the above operands
- ready_o  out  1  result valid, one-cycle pulse
- result_o  out  32  result

## Operation
- Adder usage:
  - The ALU computes alu_operand_a_o + alu_operand_b_o.
  - The usable sum is alu_adder_ext_i[32:1].
  - Bit 0 of the two operands acts as carry-in.
  - Add x+y: drive {x,1'b0} and {y,1'b0}.
  - Subtract x−y: drive {x,1'b1} and {~y,1'b1}.
- States: IDLE, ABS_A, ABS_B, COMP, LAST, CHANGE_SIGN, FINISH. A 5-bit iteration counter counts down 31→0.
- IDLE:
  - With multdiv_en_i=1, latch operands, operator and sign modes.
  - MULL goes to COMP.
  - MULH goes to COMP, then LAST.
  - DIV/REM go to ABS_A.
- ABS_A: store |A| via 0−A when A is signed and negative; otherwise store A unchanged.
- ABS_B: same as ABS_A, for B.
- COMP, multiply:
  - Shift-add with a 33-bit accumulator.
  - Sign extension per signed_mode_i; MULH uses the Baugh-Wooley correction on the top partial product.
  - 32 iterations.
- LAST (MULH only): final correction add; the upper word is taken from the accumulator.
- COMP, divide:
  - Restoring algorithm: trial subtract remainder−divisor.
  - Keep the difference if alu_adder_ext_i[32] indicates no borrow, and shift a quotient bit in.
  - 32 iterations.
- CHANGE_SIGN:
  - Negate the quotient when the signs differ and both operands are signed.
  - Negate the remainder when the dividend is negative and signed.
- FINISH: ready_o=1, result_o valid; next state IDLE.
- alu_en_o is 1 in ABS_A, ABS_B, COMP, LAST and CHANGE_SIGN; 0 in IDLE and FINISH.
- Boundary cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - MULL result is the low 32 bits regardless of signed_mode_i.
- Abort: multdiv_en_i low in any non-IDLE state returns to IDLE next cycle, with ready_o=0 and alu_en_o=0 from that cycle on.
- Reset mid-operation: abandon immediately; IDLE on the following cycle.

## Timing
- Reset values:
  - state IDLE, counter 0
  - ready_o 0, result_o 0, alu_en_o 0
  - alu_operand_a_o and alu_operand_b_o 0
- Latency is counted from the accept edge (IDLE with multdiv_en_i=1) to ready_o high:
  - MULL: 33 cycles (32 COMP + FINISH).
  - MULH: 34 cycles.
  - DIV/REM: 36 cycles.
- result_o is registered. It holds its value after FINISH until the next FINISH.
- The ALU output is consumed in the same cycle the operands are driven (combinational path through the ALU).
- Back-to-back: a new request may be accepted in the cycle immediately after FINISH.

## Configuration
- MULTDIV_DIVZERO_FASTPATH_EN
- Defined:
  - A DIV/REM with op_b_i==0 goes IDLE→FINISH.
  - ready_o is asserted 1 cycle after accept, with the divide-by-zero result.
  - alu_en_o is never asserted for that operation.
- Undefined: divide by zero takes the full 36-cycle path. The result is the same.

## Test plan
- MULL, signed 0, A=0x00000007, B=0xFFFFFFFD -> ready_o at cycle 33, result 0xFFFFFFEB.
- MULH, signed 2'b11, A=0x80000000, B=0x80000000 -> ready_o at cycle 34, result 0x40000000. MULH, signed 2'b00, A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV, signed 2'b11, A=−7 (0xFFFFFFF9), B=2 -> ready_o at cycle 36, result 0xFFFFFFFD. Same operands as REM -> 0xFFFFFFFF.
- DIV with B=0, A=0x1234 -> 0xFFFFFFFF. REM with B=0 -> 0x1234. Latency is 36 cycles without the macro and 1 cycle with it.
- DIV, signed 2'b11, A=0x80000000, B=0xFFFFFFFF -> 0x80000000. REM -> 0.
- Drop multdiv_en_i at COMP iteration 10 -> IDLE next cycle, no ready_o. Assert rst mid-DIV -> all outputs 0 next cycle. A subsequent MULL 3×5 -> 15.
